// File: rtl/stream_demux12.sv
// Registered 1-to-2 stream demux: route select is locked for a whole packet, one output register per channel.
// Optional per-channel saturating delivered-beat counters when DEMUX_COUNT_EN is defined.
module stream_demux12 #(
  parameter int DATA_W = 8
`ifdef DEMUX_COUNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              s,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              a_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_last,
  output logic              busy
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
`endif
);

  typedef enum logic [1:0] {IDLE, ROUTE_A, ROUTE_B} state_t;

  state_t              state_q, state_d;
  logic                busy_q;
  logic                a_valid_q, b_valid_q;
  logic [DATA_W-1:0]   a_data_q, b_data_q;
  logic                a_last_q, b_last_q;
  logic                route_b;
  logic                accept;
  logic                load_a, load_b;

  // s only matters between packets; mid-packet the locked route wins.
  assign route_b  = (state_q == IDLE) ? s : (state_q == ROUTE_B);
  assign in_ready = route_b ? (!b_valid_q || b_ready) : (!a_valid_q || a_ready);
  assign accept   = in_valid && in_ready;
  assign load_a   = accept && !route_b;
  assign load_b   = accept && route_b;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_last)
        state_d = IDLE;
      else if (state_q == IDLE)
        state_d = route_b ? ROUTE_B : ROUTE_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // A load in the same cycle as a drain simply replaces the old beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_last_q  <= 1'b0;
    end else if (load_a) begin
      a_valid_q <= 1'b1;
      a_data_q  <= in_data;
      a_last_q  <= in_last;
    end else if (a_valid_q && a_ready) begin
      a_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_last_q  <= 1'b0;
    end else if (load_b) begin
      b_valid_q <= 1'b1;
      b_data_q  <= in_data;
      b_last_q  <= in_last;
    end else if (b_valid_q && b_ready) begin
      b_valid_q <= 1'b0;
    end
  end

  assign a_valid = a_valid_q;
  assign a_data  = a_data_q;
  assign a_last  = a_last_q;
  assign b_valid = b_valid_q;
  assign b_data  = b_data_q;
  assign b_last  = b_last_q;
  assign busy    = busy_q;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] a_cnt_q, b_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (a_valid_q && a_ready && (a_cnt_q != '1))
        a_cnt_q <= a_cnt_q + CNT_W'(1);
      if (b_valid_q && b_ready && (b_cnt_q != '1))
        b_cnt_q <= b_cnt_q + CNT_W'(1);
    end
  end

  assign a_count = a_cnt_q;
  assign b_count = b_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux12.sv
// Bench for stream_demux12: directed scenarios, then random traffic against a packet-level queue model.
module tb_stream_demux12;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          s = 1'b0;
  logic          a_valid, a_ready = 1'b0, a_last;
  logic          b_valid, b_ready = 1'b0, b_last;
  logic [DW-1:0] a_data, b_data;
  logic          busy;
`ifdef DEMUX_COUNT_EN
  logic [1:0]    a_count, b_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux12 #(
    .DATA_W(DW)
`ifdef DEMUX_COUNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .s(s),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .busy(busy)
`ifdef DEMUX_COUNT_EN
    , .a_count(a_count), .b_count(b_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic sel);
    in_valid = v; in_data = d; in_last = l; s = sel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Reference model: one FIFO of expected beats per channel plus the packet route lock.
  typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
  beat_t qa[$], qb[$];
  bit    mid, rb, tgt, exp_rdy, pa, pb;
  int    ca, cb;

  initial begin
    // Async reset with a beat parked on A
    step();
    rst = 1'b0;
    drive(1, 8'h77, 1, 0);
    step();
    in_valid = 1'b0;
    chk("park_a_valid", a_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    rst = 1'b0;

    // Single beat on A
    a_ready = 1; b_ready = 0;
    drive(1, 8'h5A, 1, 0);
    step();
    chk("single_a_valid", a_valid, 1);
    chk("single_a_data", a_data, 8'h5A);
    chk("single_a_last", a_last, 1);
    chk("single_b_valid", b_valid, 0);
    chk("single_busy", busy, 0);
    in_valid = 0;
    step();
    chk("single_drained", a_valid, 0);

    // Packet lock: s changes mid-packet but route stays B
    b_ready = 1;
    drive(1, 8'h01, 0, 1);
    step();
    chk("lock1_data", b_data, 8'h01);
    chk("lock1_last", b_last, 0);
    chk("lock1_busy", busy, 1);
    drive(1, 8'h02, 0, 0);
    step();
    chk("lock2_data", b_data, 8'h02);
    chk("lock2_a_valid", a_valid, 0);
    chk("lock2_busy", busy, 1);
    drive(1, 8'h03, 1, 0);
    step();
    chk("lock3_data", b_data, 8'h03);
    chk("lock3_last", b_last, 1);
    chk("lock3_busy", busy, 0);
    chk("lock3_a_valid", a_valid, 0);
    in_valid = 0;
    step();

    // Backpressure on B with bubble-free replacement
    b_ready = 0;
    drive(1, 8'h11, 1, 1);
    step();
    drive(1, 8'h22, 1, 1);
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    step();
    chk("bp_hold_data", b_data, 8'h11);
    chk("bp_hold_valid", b_valid, 1);
    b_ready = 1;
    #1;
    chk("bp_in_ready_high", in_ready, 1);
    step();
    chk("bp_replace_valid", b_valid, 1);
    chk("bp_replace_data", b_data, 8'h22);
    in_valid = 0;
    step();
    chk("bp_drained", b_valid, 0);

    // Independence: stalled A does not block B
    a_ready = 0;
    drive(1, 8'h33, 1, 0);
    step();
    drive(1, 8'h44, 1, 1);
    #1;
    chk("ind_in_ready", in_ready, 1);
    step();
    chk("ind_b_data", b_data, 8'h44);
    chk("ind_b_valid", b_valid, 1);
    chk("ind_a_data", a_data, 8'h33);
    chk("ind_a_valid", a_valid, 1);
    in_valid = 0; a_ready = 1;
    step();

    // Reset during beat 2 of a 4-beat packet on A
    drive(1, 8'h51, 0, 0);
    step();
    drive(1, 8'h52, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_a_valid", a_valid, 0);
    chk("mid_rst_b_valid", b_valid, 0);
    chk("mid_rst_busy", busy, 0);
    in_valid = 0;
    step();
    rst = 1'b0;
    drive(1, 8'h66, 1, 1);   // lands on B only if the FSM really is back in IDLE
    step();
    chk("mid_rst_idle_b", b_valid, 1);
    chk("mid_rst_idle_a", a_valid, 0);
    in_valid = 0;
    step();

`ifdef DEMUX_COUNT_EN
    pulse_reset();
    a_ready = 1; b_ready = 1;
    for (int i = 0; i <= 5; i++) begin
      drive(i < 5, DW'(i), 1, 0);
      step();
      if (i >= 1) begin
        chk("sat_a_count", a_count, (i > 3) ? 3 : i);
        chk("sat_b_count", b_count, 0);
      end
    end
`endif

    // Random traffic against the queue model
    pulse_reset();
    mid = 0; rb = 0; ca = 0; cb = 0;
    qa.delete(); qb.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      a_ready = $urandom_range(0, 3) != 0;
      b_ready = $urandom_range(0, 2) != 0;
      #1;
      chk("rnd_a_valid", a_valid, qa.size() != 0);
      chk("rnd_b_valid", b_valid, qb.size() != 0);
      if (qa.size() != 0) chk("rnd_a_beat", {a_last, a_data}, qa[0]);
      if (qb.size() != 0) chk("rnd_b_beat", {b_last, b_data}, qb[0]);
      chk("rnd_busy", busy, mid);
`ifdef DEMUX_COUNT_EN
      chk("rnd_a_count", a_count, (ca > 3) ? 3 : ca);
      chk("rnd_b_count", b_count, (cb > 3) ? 3 : cb);
`endif
      tgt     = mid ? rb : s;
      exp_rdy = tgt ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready);
      chk("rnd_in_ready", in_ready, exp_rdy);
      pa = (qa.size() != 0) && a_ready;
      pb = (qb.size() != 0) && b_ready;
      if (pa) begin void'(qa.pop_front()); ca++; end
      if (pb) begin void'(qb.pop_front()); cb++; end
      if (in_valid && exp_rdy) begin
        if (tgt) qb.push_back({in_last, in_data});
        else     qa.push_back({in_last, in_data});
        if (!mid && !in_last) begin mid = 1; rb = s; end
        else if (mid && in_last) mid = 0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux12.md
Name: stream_demux12

Overview:
- Registered 1-to-2 stream demultiplexer; the routing counterpart of the team's 2:1 select mux.
- Takes one valid/ready packet stream and steers each packet to output A or B.
- The select input is sampled on the first beat of a packet and locked until the last beat.
- Each output has a one-entry pipeline register, so outputs are glitch-free and backpressure is honoured per channel.

Parameters:
DATA_W, 8, width of data on input and both outputs
CNT_W, 16, width of per-channel beat counters (used only with DEMUX_COUNT_EN)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_data  input  DATA_W  input beat data
in_last  input  1  final beat of a packet
s  input  1  route select, sampled on a packet's first beat: 0 = A, 1 = B
a_valid  output  1  channel A beat valid
a_ready  input  1  channel A downstream ready
a_data  output  DATA_W  channel A data
a_last  output  1  channel A last-beat flag
b_valid  output  1  channel B beat valid
b_ready  input  1  channel B downstream ready
b_data  output  DATA_W  channel B data
b_last  output  1  channel B last-beat flag
busy  output  1  high while a multi-beat packet is mid-transfer
a_count  output  CNT_W  beats delivered on A (DEMUX_COUNT_EN only)
b_count  output  CNT_W  beats delivered on B (DEMUX_COUNT_EN only)

Behaviour:
- Reset (asynchronous, active-high): a_valid/b_valid=0, a_data/b_data=0, a_last/b_last=0, state=IDLE, busy=0, counters=0. Reset asserted mid-packet discards all in-flight beats and returns to IDLE.
- FSM states: IDLE, ROUTE_A, ROUTE_B.
- Target channel: in IDLE it is s (combinational); in ROUTE_A/ROUTE_B it is A/B. s is ignored outside IDLE.
- in_ready = (target register empty) || (target x_ready). This is combinational and allows one beat per cycle at full throughput. It does not depend on the non-target channel.
- Accepted beat: loaded into the target register on the next edge (latency 1 cycle); x_valid=1, x_data=in_data, x_last=in_last.
- Transitions:
  - IDLE + accepted beat with in_last=0 -> ROUTE_A or ROUTE_B per s.
  - IDLE + accepted beat with in_last=1 -> stay IDLE (single-beat packet).
  - ROUTE_x + accepted beat with in_last=1 -> IDLE.
  - No accepted beat -> hold state.
- Output register:
  - Cleared (x_valid=0) on x_valid && x_ready when no new beat loads in the same cycle.
  - Simultaneous drain and load: new beat replaces old, x_valid stays 1.
  - While x_valid && !x_ready, x_data and x_last are held stable.
- Channels drain independently; a stalled channel never blocks beats routed to the other channel.
- busy = (state != IDLE), registered.
- Counters (macro only): x_count increments on each x_valid && x_ready and saturates at all-ones (2^CNT_W-1). It does not wrap.

Optional Feature:
- DEMUX_COUNT_EN defined: a_count/b_count ports and counter logic are present, behaving as above.
- DEMUX_COUNT_EN undefined: the ports and logic are removed; all other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously between edges -> a_valid=b_valid=0, busy=0, in_ready=1 immediately with a_ready=b_ready=0.
- Single beat: s=0, in_data=0x5A, in_last=1, a_ready=1 -> a_valid=1 and a_data=0x5A one cycle later; b_valid stays 0; busy stays 0.
- Packet lock: 3 beats 0x01,0x02,0x03 with s=1 on beat 1, s=0 on beats 2-3 -> all three on B in order; b_last=1 only on 0x03; busy=1 from after beat 1 until after beat 3; A untouched.
- Backpressure: b_ready=0, send 0x11 then 0x22 to B -> 0x11 held stable on b_data; in_ready=0 for 0x22; raise b_ready -> 0x11 drains and 0x22 loads in the same cycle with no bubble.
- Independence / reset mid-packet:
  - A holding 0x33 with a_ready=0, send single beat 0x44 s=1 -> 0x44 delivered on B while A still holds 0x33.
  - Assert rst during beat 2 of a 4-beat packet -> all valids 0, state IDLE.
- Counter saturation (DEMUX_COUNT_EN, CNT_W=2): deliver 5 beats on A -> a_count reads 1,2,3,3,3 and b_count stays 0.
